// File: rtl/sram_emu.sv
// Block-RAM backed responder for the async-SRAM pin protocol (CS/OE/WE active low); optional SRAM_EMU_FAULT_EN flips FAULT_BIT on reads of FAULT_ADDR.
// Latency: pins to registered inputs 1 edge; read data and sram_d_oe valid 2 edges after the sampled request; a write commits 1 edge after WE/CS rise is sampled.
// Backpressure: none; the initiator must hold each control phase for at least 3 clk cycles.
module sram_emu #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FAULT_ADDR = 'h5A,
    parameter int unsigned FAULT_BIT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] sram_addr,
    input  logic        sram_cs,
    input  logic        sram_oe,
    input  logic        sram_we,
    input  logic [15:0] sram_d_in,
    output logic [15:0] sram_d_out,
    output logic        sram_d_oe,
    output logic [7:0]  wr_cnt,
    output logic [7:0]  rd_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef SRAM_EMU_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] FAULT_A    = ADDR_W'(FAULT_ADDR);
    localparam logic [15:0]       FAULT_MASK = 16'd1 << FAULT_BIT;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                cs_q;
    logic                oe_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         din_q;
    logic [ADDR_W-1:0]   pend_addr;
    logic [15:0]         pend_data;
    logic [15:0]         rd_data;
    logic                wr_commit;
    logic                rd_enter;
    logic                rd_hold;
    logic                fault_hit;
    logic                unused_addr_hi;

    // Array starts zeroed; reset deliberately leaves contents alone.
    logic [15:0] mem [DEPTH] = '{default: 16'h0000};

    assign unused_addr_hi = ^sram_addr[17:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q   <= 1'b1;
            oe_q   <= 1'b1;
            we_q   <= 1'b1;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            cs_q   <= sram_cs;
            oe_q   <= sram_oe;
            we_q   <= sram_we;
            addr_q <= sram_addr[ADDR_W-1:0];
            din_q  <= sram_d_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!cs_q && !we_q)      state_d = ST_WRITE;
                else if (!cs_q && !oe_q) state_d = ST_READ;
            end
            ST_READ: begin
                if (!cs_q && !we_q)      state_d = ST_WRITE;
                else if (cs_q || oe_q)   state_d = ST_IDLE;
            end
            ST_WRITE: begin
                if (we_q || cs_q)        state_d = (!cs_q && !oe_q) ? ST_READ : ST_IDLE;
            end
            default:                     state_d = ST_IDLE;
        endcase
    end

    assign wr_commit = (state_q == ST_WRITE) && (state_d != ST_WRITE);
    assign rd_enter  = (state_q != ST_READ)  && (state_d == ST_READ);
    assign rd_hold   = (state_q == ST_READ)  && (state_d == ST_READ);
    assign fault_hit = FAULT_EN && (addr_q == FAULT_A);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_addr  <= '0;
            pend_data  <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            sram_d_out <= '0;
            sram_d_oe  <= 1'b0;
        end else begin
            state_q <= state_d;
            // Keep the last address/data seen with WE low; latching stops on the exit edge.
            if (state_d == ST_WRITE) begin
                pend_addr <= addr_q;
                pend_data <= din_q;
            end
            if (wr_commit) wr_cnt <= wr_cnt + 8'd1;
            if (rd_enter)  rd_cnt <= rd_cnt + 8'd1;
            sram_d_oe <= rd_hold;
            if (rd_hold) sram_d_out <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit && !rst) mem[pend_addr] <= pend_data;
        rd_data <= mem[addr_q] ^ (fault_hit ? FAULT_MASK : 16'h0000);
    end

endmodule

// File: doc/sram_emu.md
# sram_emu

Synthesizable on-chip responder for the asynchronous-SRAM pin protocol (active-low CS/OE/WE, 18-bit address, 16-bit data) that the design's SRAM test initiator drives. It backs the protocol with an internal block-RAM array so the initiator can be exercised in loopback on the FPGA without the external chip. It also provides a deterministic fault source for checking the initiator's error path. It sits beside the SRAM tester in the top level, and a top-level mux selects between the external pins and this block.

## Interface
Parameters:
- ADDR_W, 8: internal address width; depth 2^ADDR_W words; uses sram_addr[ADDR_W-1:0], ignores upper bits.
- FAULT_ADDR, 8'h5A: word address affected by the fault injector.
- FAULT_BIT, 3: data bit inverted on faulty reads (0..15).

Ports:
- clk, in, 1: system clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- sram_addr, in, 18: address from the initiator.
- sram_cs, in, 1: chip select, active low.
- sram_oe, in, 1: output enable, active low.
- sram_we, in, 1: write enable, active low.
- sram_d_in, in, 16: write data from the initiator.
- sram_d_out, out, 16: read data to the initiator.
- sram_d_oe, out, 1: high when this block drives the data bus.
- wr_cnt, out, 8: committed-write counter; wraps.
- rd_cnt, out, 8: read-access counter; wraps.

## Operation
- Input stage: every edge registers cs_q, oe_q, we_q, addr_q and din_q from the pins. All decisions use these registered copies.
- State machine: IDLE, READ, WRITE.
  - IDLE -> WRITE when cs_q=0 and we_q=0. WE has priority over OE.
  - IDLE -> READ when cs_q=0, oe_q=0 and we_q=1.
  - READ -> IDLE when cs_q=1 or oe_q=1. READ -> WRITE when we_q=0.
  - WRITE -> IDLE or READ when we_q=1 or cs_q=1. The target follows the IDLE rules.
- Write: in WRITE, every cycle latches pend_addr<=addr_q and pend_data<=din_q. On the exit edge the block writes mem[pend_addr]<=pend_data and increments wr_cnt, so the last data seen before the WE or CS rising edge is stored.
- Read: each entry into READ increments rd_cnt once. While in READ, the block reads mem[addr_q] every cycle, so address changes with OE held low produce new data (page-style reads).
- sram_d_oe is high only in READ after the output pipeline fills. It is never high in WRITE.
- Counters wrap 255 -> 0 silently.
- Memory is not cleared by reset. Initial contents are all zero.

## Timing
- Reset values: sram_d_out=0, sram_d_oe=0, wr_cnt=0, rd_cnt=0, state IDLE, pend registers 0.
- Reset asserted mid-WRITE discards the pending write: no memory update, no count.
- Read latency: pins valid before edge E0 -> sram_d_out valid and sram_d_oe=1 after edge E0+2.
- Address change in READ at E0 -> new data after E0+2.
- Read release: deselect sampled at E0 -> sram_d_oe=0 after E0+1. sram_d_out holds its last value.
- Write commit: WE or CS rises before E0 -> memory is updated at E0+1. A read of that address issued from E0+1 onward returns the new data.
- Initiator contract: hold each control phase for at least 3 clk cycles. Shorter pulses are sampled as-is with no glitch filtering.
- Throughput: one read word per cycle in READ; one write per WRITE episode.

## Configuration
- SRAM_EMU_FAULT_EN defined: reads where addr_q[ADDR_W-1:0]==FAULT_ADDR return stored data with bit FAULT_BIT inverted. Memory contents are unaffected, and write and counter behaviour is unchanged.
- Undefined: FAULT_ADDR and FAULT_BIT are ignored and reads return stored data exactly.

## Test plan
- Write then read: CS=0/WE=0 for 4 cycles with addr 0x12 and data 0xA5C3, WE=1, then CS=0/OE=0 at addr 0x12. Required: sram_d_out=0xA5C3 with sram_d_oe=1 two edges after the read is sampled; wr_cnt=1, rd_cnt=1.
- Page read: write 0x0001..0x0004 to addr 0..3, then hold OE low and step the address every 3 cycles. Required: each value appears 2 edges after its address, and rd_cnt increments only once.
- Contention: CS=0 with OE=0 and WE=0 together for 5 cycles, data 0xBEEF at addr 7. Required: sram_d_oe stays 0 throughout; after release, a read of addr 7 returns 0xBEEF.
- Reset mid-write: start a write of 0x1234 to addr 9 over existing 0, assert rst for 1 cycle while WE is low, then release. Required: addr 9 reads 0, wr_cnt=0, and all outputs are 0 during reset.
- Wrap: perform 256 writes. Required: wr_cnt reads 255 after 255 writes and 0 after the 256th.
- Fault injection, with SRAM_EMU_FAULT_EN defined: write 0x0000 to 0x5A. Required: read returns 0x0008; addr 0x5B reads back as written. Without the macro, 0x5A returns 0x0000.
